// File: rtl/npn_lut_eval.sv
// Programmable NPN-transformed truth-table evaluator with a two-stage valid/ready pipeline.
// Stage 1 registers the permuted/negated index, stage 2 registers the table lookup.
module npn_lut_eval #(
   parameter int NUM_INPUTS = 4,
   parameter int SEL_W      = $clog2(NUM_INPUTS),
   parameter int TT_W       = 2**NUM_INPUTS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [TT_W-1:0]             cfg_tt,
   input  logic [NUM_INPUTS*SEL_W-1:0] cfg_perm,
   input  logic [NUM_INPUTS-1:0]       cfg_neg,
   input  logic                        cfg_out_neg,
   output logic                        cfg_err,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_INPUTS-1:0]       x,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        y0
);

   localparam int SEL_SPAN = 2**SEL_W;

   function automatic logic [NUM_INPUTS*SEL_W-1:0] identity_perm();
      logic [NUM_INPUTS*SEL_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_INPUTS; i++) p[i*SEL_W +: SEL_W] = SEL_W'(i);
      return p;
   endfunction

   localparam logic [NUM_INPUTS*SEL_W-1:0] PERM_ID = identity_perm();

   logic [TT_W-1:0]             tt_q, tt_d;
   logic [NUM_INPUTS*SEL_W-1:0] perm_q, perm_d;
   logic [NUM_INPUTS-1:0]       neg_q, neg_d;
   logic                        out_neg_q, out_neg_d;
   logic                        loaded_q, loaded_d;
   logic                        cfg_err_q, cfg_err_d;
   logic                        s1_valid_q, s1_valid_d;
   logic [NUM_INPUTS-1:0]       idx_q, idx_d;
   logic                        out_valid_q, out_valid_d;
   logic                        y0_q, y0_d;

   logic                        in_fire, cfg_fire, s2_load, s1_adv, perm_ok;
   logic [SEL_SPAN-1:0]         seen;
   logic [SEL_SPAN-1:0]         x_ext;
   logic [NUM_INPUTS-1:0]       idx_new;

   always_comb begin
      // Out-of-range selectors land above bit NUM_INPUTS-1, so with exactly
      // NUM_INPUTS slices the low bits are all set only for a true permutation.
      seen = '0;
      for (int i = 0; i < NUM_INPUTS; i++) seen[cfg_perm[i*SEL_W +: SEL_W]] = 1'b1;
      perm_ok = &seen[NUM_INPUTS-1:0];

      x_ext = '0;
      x_ext[NUM_INPUTS-1:0] = x;
      idx_new = '0;
      for (int i = 0; i < NUM_INPUTS; i++) idx_new[i] = x_ext[perm_q[i*SEL_W +: SEL_W]] ^ neg_q[i];
   end

   always_comb begin
      s2_load   = !out_valid_q || out_ready;
      s1_adv    = s1_valid_q && s2_load;
      in_ready  = loaded_q && (!s1_valid_q || s2_load);
      in_fire   = in_valid && in_ready;
      cfg_ready = !s1_valid_q && !out_valid_q && !in_fire;
      cfg_fire  = cfg_valid && cfg_ready;

      tt_d        = tt_q;
      perm_d      = perm_q;
      neg_d       = neg_q;
      out_neg_d   = out_neg_q;
      loaded_d    = loaded_q;
      cfg_err_d   = cfg_fire && !perm_ok;
      s1_valid_d  = s1_valid_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      y0_d        = y0_q;

      if (cfg_fire && perm_ok) begin
         tt_d      = cfg_tt;
         perm_d    = cfg_perm;
         neg_d     = cfg_neg;
         out_neg_d = cfg_out_neg;
         loaded_d  = 1'b1;
      end

      if (in_fire) begin
         s1_valid_d = 1'b1;
         idx_d      = idx_new;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) y0_d = tt_q[idx_q] ^ out_neg_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_q        <= '0;
         perm_q      <= PERM_ID;
         neg_q       <= '0;
         out_neg_q   <= 1'b0;
         loaded_q    <= 1'b0;
         cfg_err_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         y0_q        <= 1'b0;
      end else begin
         tt_q        <= tt_d;
         perm_q      <= perm_d;
         neg_q       <= neg_d;
         out_neg_q   <= out_neg_d;
         loaded_q    <= loaded_d;
         cfg_err_q   <= cfg_err_d;
         s1_valid_q  <= s1_valid_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         y0_q        <= y0_d;
      end
   end

   assign cfg_err   = cfg_err_q;
   assign out_valid = out_valid_q;
   assign y0        = y0_q;

endmodule

// File: tb/tb_npn_lut_eval.sv
// Scoreboard bench for npn_lut_eval: directed vectors push expected results, a monitor pops on output handshakes.
module tb_npn_lut_eval;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [15:0]  cfg_tt = '0;
   logic [7:0]   cfg_perm = '0;
   logic [3:0]   cfg_neg = '0;
   logic         cfg_out_neg = 1'b0;
   logic         cfg_err;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   x = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         y0;

   npn_lut_eval #(.NUM_INPUTS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tt(cfg_tt), .cfg_perm(cfg_perm),
      .cfg_neg(cfg_neg), .cfg_out_neg(cfg_out_neg), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .y0(y0)
   );

   always #5 clk = ~clk;

   logic        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          results_seen = 0;
   bit          chk_bp = 1'b0;
   bit          bp_en = 1'b0;
   bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int          ph = 0;
   logic [15:0] tt_ref = 16'h16AC;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         results_seen++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got y0=%0b expected no result at %0t", y0, $time);
         end else begin
            check("result", y0, exp_q.pop_front());
         end
      end
   end

   // in_ready must drop only when the output is stalled (stage 1 is full during streaming)
   always @(negedge clk) begin
      if (chk_bp) check("in_ready_bp", in_ready, !(out_valid && !out_ready));
   end

   always @(posedge clk) begin
      if (bp_en) begin
         #1;
         out_ready = pat[ph];
         ph = (ph + 1) % 4;
      end
   end

   task automatic send(input logic [3:0] xv, input logic e);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      x = xv;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (got) exp_q.push_back(e);
      else check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [15:0] tt, input logic [7:0] perm, input logic [3:0] ng,
                         input logic on, input logic exp_err);
      bit got;
      got = 1'b0;
      cfg_valid = 1'b1;
      cfg_tt = tt;
      cfg_perm = perm;
      cfg_neg = ng;
      cfg_out_neg = on;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cfg_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("cfg_timeout", 0, 1);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("cfg_err", cfg_err, exp_err);
      @(negedge clk);
      check("cfg_err_end", cfg_err, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_y0", y0, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_cfg_ready", cfg_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // No configuration yet: nothing accepted
      in_valid = 1'b1;
      x = 4'b0011;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("noload_in_ready", in_ready, 0);
         check("noload_out_valid", out_valid, 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;

      do_cfg(16'h16AC, 8'hE4, 4'b0000, 1'b0, 1'b0);
      send(4'b0011, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_1", out_valid, 0);
      @(negedge clk);
      check("latency_2", out_valid, 1);
      drain();
      send(4'b0000, 1'b0);
      in_valid = 1'b0;
      drain();

      do_cfg(16'h16AC, 8'hE4, 4'b0001, 1'b0, 1'b0);
      send(4'b0011, 1'b1);
      in_valid = 1'b0;
      drain();
      do_cfg(16'h16AC, 8'hE4, 4'b0001, 1'b1, 1'b0);
      send(4'b0011, 1'b0);
      in_valid = 1'b0;
      drain();

      do_cfg(16'h16AC, 8'hE1, 4'b0000, 1'b0, 1'b0);
      send(4'b0001, 1'b1);
      in_valid = 1'b0;
      drain();
      do_cfg(16'h16AC, 8'hE4, 4'b0000, 1'b0, 1'b0);
      send(4'b0001, 1'b0);
      in_valid = 1'b0;
      drain();

      // Rejected config must leave 16'h16AC / identity / no negation in place
      do_cfg(16'hFFFF, 8'hE0, 4'b1111, 1'b1, 1'b1);
      send(4'b0011, 1'b1);
      in_valid = 1'b0;
      drain();

      // Input and config offered together while idle: input wins
      in_valid = 1'b1;
      x = 4'b0000;
      cfg_valid = 1'b1;
      cfg_tt = 16'hFFFF;
      cfg_perm = 8'hE4;
      cfg_neg = 4'b0000;
      cfg_out_neg = 1'b1;
      @(negedge clk);
      check("simul_cfg_ready", cfg_ready, 0);
      check("simul_in_ready", in_ready, 1);
      if (in_ready) exp_q.push_back(1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_valid = 1'b0;
      drain();
      send(4'b0011, 1'b1);
      in_valid = 1'b0;
      drain();

      // Stream all 16 vectors with out_ready toggling 1,0,0,1
      base = results_seen;
      ph = 0;
      bp_en = 1'b1;
      chk_bp = 1'b1;
      for (int i = 0; i < 16; i++) send(4'(i), tt_ref[i]);
      chk_bp = 1'b0;
      in_valid = 1'b0;
      drain();
      bp_en = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      check("stream_count", results_seen - base, 16);

      // Reset with two vectors in flight
      out_ready = 1'b0;
      send(4'b0001, tt_ref[1]);
      send(4'b0010, tt_ref[2]);
      in_valid = 1'b0;
      @(negedge clk);
      check("inflight_out_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_flush_out_valid", out_valid, 0);
      check("reset_cfg_ready", cfg_ready, 1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_rst_in_ready", in_ready, 0);
         check("post_rst_out_valid", out_valid, 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      do_cfg(16'h16AC, 8'hE4, 4'b0000, 1'b0, 1'b0);
      send(4'b0101, 1'b1);
      in_valid = 1'b0;
      drain();
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
